mult_output: RTL and testbench
==============================

MULT_OUTPUT -- requirements
Module: mult_output

Interface
REQ-001 Parameter: WIDTH, 64, operand and result width in bits; only 64 is required to be supported.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk, input, 1, rising-edge clock for all state.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: A, input, 64, multiplicand.
REQ-006 Port: B, input, 64, multiplier.
REQ-007 Port: opcode, input, 5, operation select.
REQ-008 Port: Y, output, 64, registered result.

Function
REQ-009 Opcode encoding: 5'b01100 = MUL, 5'b01101 = MULH, 5'b01110 = MULHSU, 5'b01111 = MULHU.
REQ-010 Full product P is 128 bits and is formed by a 64x64 partial-product array reduced with a Dadda tree and summed by a final carry-propagate adder.
REQ-011 Operand interpretation:
- MUL and MULHU: A and B are both unsigned.
- MULH: A and B are both two's-complement signed.
- MULHSU: A is signed and B is unsigned.
REQ-012 Signed handling is by sign extension (or Baugh-Wooley correction) so that P equals the exact mathematical product modulo 2^128.
REQ-013 Output select: MUL produces P[63:0]; MULH, MULHSU and MULHU produce P[127:64].
REQ-014 Any other opcode value produces Y = 64'h0.
REQ-015 Latency is exactly 1 cycle: A, B and opcode are sampled at a rising clk edge, and Y shows that result after the edge.
REQ-016 A new operation may be issued every cycle; there is no handshake and no stall.
REQ-017 Y holds its value until the next rising clk edge and is glitch-free, because it is driven directly from a register.
REQ-018 Results are bit-exact for all boundary operands, including 0, 1, all-ones, the most negative value 64'h8000_0000_0000_0000, and powers of two.
REQ-019 No overflow flag exists; bits of P outside the selected half are discarded.
REQ-020 The combinational path from A/B/opcode to the Y register fits within one clock period; internal pipelining is not permitted.

Reset
REQ-021 While rst_n = 0, Y = 64'h0 immediately, with no clock required.
REQ-022 Deassertion of rst_n is synchronised to clk; the first capture occurs on the first rising edge with rst_n = 1.
REQ-023 Asserting rst_n mid-operation discards the in-flight result; Y stays 0 until a capture edge occurs after release.

Verification
REQ-024 MUL, A = 15, B = 10 -> Y = 150 one cycle later.
REQ-025 MULHU, A = B = 64'hFFFF_FFFF_FFFF_FFFF -> Y = 64'hFFFF_FFFF_FFFF_FFFE; MULHU, A = 7, B = 6 -> Y = 0.
REQ-026 MUL, A = 64'h1_0000_0000, B = 2 -> Y = 64'h2_0000_0000.
REQ-027 MULH, A = 64'hFFFF_FFFF_FFFF_FFFF, B = 2 -> Y = 64'hFFFF_FFFF_FFFF_FFFF; MULHSU with the same operands -> Y = 64'hFFFF_FFFF_FFFF_FFFF; MULHU with the same operands -> Y = 1.
REQ-028 MULH, A = B = 64'h8000_0000_0000_0000 -> Y = 64'h4000_0000_0000_0000; opcode = 5'b00000 -> Y = 0.
REQ-029 Back-to-back ops over consecutive cycles each appear exactly one cycle later, and a random compare against a 128-bit reference model passes.
REQ-030 Reset case: rst_n is pulled low between clock edges while Y is non-zero -> Y = 0 at once, and Y stays 0 until the first post-release edge.

Source files
------------

// File: rtl/mult_output.sv
// Registered 64x64 multiplier producing MUL / MULH / MULHSU / MULHU results.
// The 128-bit product comes from an unsigned AND-array plus two-row sign
// correction, reduced by a Dadda tree and summed by one carry-propagate add.
module mult_output #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       opcode,
    output logic [WIDTH-1:0] Y
);

    typedef enum logic [4:0] {
        OP_MUL    = 5'b01100,
        OP_MULH   = 5'b01101,
        OP_MULHSU = 5'b01110,
        OP_MULHU  = 5'b01111
    } op_e;

    // Dadda target height j: d(0) = 2, d(j+1) = floor(1.5 * d(j)).
    function automatic int unsigned dadda_d(input int unsigned j);
        int unsigned d;
        d = 2;
        for (int unsigned i = 0; i < j; i++) d = (d * 3) / 2;
        return d;
    endfunction

    // Number of Dadda targets strictly below the tallest column.
    function automatic int unsigned dadda_stages(input int unsigned maxh);
        int unsigned n;
        int unsigned d;
        n = 0;
        d = 2;
        while (d < maxh) begin
            n++;
            d = (d * 3) / 2;
        end
        return n;
    endfunction

    localparam int unsigned PW     = 2 * WIDTH;
    // Tallest column is WIDTH: WIDTH-1 AND terms, two correction rows, two +1 terms.
    localparam int unsigned MAXH   = WIDTH + 4;
    localparam int unsigned NSTAGE = dadda_stages(WIDTH + 3);
    localparam int unsigned CW     = $clog2(PW);
    localparam int unsigned HW     = $clog2(MAXH);
    localparam int unsigned AW     = $clog2(WIDTH);

    logic              a_neg;
    logic              b_neg;
    logic [MAXH-1:0]   col [PW];
    logic [MAXH-1:0]   nxt [PW];
    int unsigned       ht  [PW];
    int unsigned       nht [PW];
    int unsigned       tgt;
    int unsigned       rem;
    int unsigned       k;
    logic              x0, x1, x2;
    logic [PW-1:0]     row0;
    logic [PW-1:0]     row1;
    logic [PW-1:0]     prod;
    logic [WIDTH-1:0]  y_d;
    logic [WIDTH-1:0]  y_q;

    // Decode which operand is signed and currently negative.
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (opcode == OP_MULH) begin
            a_neg = A[WIDTH-1];
            b_neg = B[WIDTH-1];
        end else if (opcode == OP_MULHSU) begin
            a_neg = A[WIDTH-1];
        end
    end

    // Build the partial-product matrix, Dadda-reduce it to two rows, then add.
    always_comb begin
        tgt  = 0;
        rem  = 0;
        k    = 0;
        x0   = 1'b0;
        x1   = 1'b0;
        x2   = 1'b0;
        row0 = '0;
        row1 = '0;
        for (int unsigned c = 0; c < PW; c++) begin
            col[CW'(c)] = '0;
            nxt[CW'(c)] = '0;
            ht[CW'(c)]  = 0;
            nht[CW'(c)] = 0;
        end

        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                col[CW'(i + j)][HW'(ht[CW'(i + j)])] = A[AW'(j)] & B[AW'(i)];
                ht[CW'(i + j)] = ht[CW'(i + j)] + 1;
            end
        end

        // A signed operand's MSB weighs -2^(WIDTH-1), so subtract the other
        // operand shifted by WIDTH: add its complement plus one at bit WIDTH.
        for (int unsigned j = 0; j < WIDTH; j++) begin
            col[CW'(WIDTH + j)][HW'(ht[CW'(WIDTH + j)])] = a_neg & ~B[AW'(j)];
            ht[CW'(WIDTH + j)] = ht[CW'(WIDTH + j)] + 1;
            col[CW'(WIDTH + j)][HW'(ht[CW'(WIDTH + j)])] = b_neg & ~A[AW'(j)];
            ht[CW'(WIDTH + j)] = ht[CW'(WIDTH + j)] + 1;
        end
        col[CW'(WIDTH)][HW'(ht[CW'(WIDTH)])] = a_neg;
        ht[CW'(WIDTH)] = ht[CW'(WIDTH)] + 1;
        col[CW'(WIDTH)][HW'(ht[CW'(WIDTH)])] = b_neg;
        ht[CW'(WIDTH)] = ht[CW'(WIDTH)] + 1;

        for (int unsigned s = NSTAGE; s > 0; s--) begin
            tgt = dadda_d(s - 1);
            for (int unsigned c = 0; c < PW; c++) begin
                nxt[CW'(c)] = '0;
                nht[CW'(c)] = 0;
            end
            // Carries land in the next column of the new stage before that
            // column is visited, so nht already counts them when it is reduced.
            for (int unsigned c = 0; c < PW; c++) begin
                k   = 0;
                rem = ht[CW'(c)];
                while ((rem + nht[CW'(c)] > tgt) && (rem >= 2)) begin
                    x0 = col[CW'(c)][HW'(k)];
                    x1 = col[CW'(c)][HW'(k + 1)];
                    if ((rem + nht[CW'(c)] == tgt + 1) || (rem == 2)) begin
                        nxt[CW'(c)][HW'(nht[CW'(c)])] = x0 ^ x1;
                        nht[CW'(c)] = nht[CW'(c)] + 1;
                        if (c + 1 < PW) begin
                            nxt[CW'(c + 1)][HW'(nht[CW'(c + 1)])] = x0 & x1;
                            nht[CW'(c + 1)] = nht[CW'(c + 1)] + 1;
                        end
                        k   = k + 2;
                        rem = rem - 2;
                    end else begin
                        x2 = col[CW'(c)][HW'(k + 2)];
                        nxt[CW'(c)][HW'(nht[CW'(c)])] = x0 ^ x1 ^ x2;
                        nht[CW'(c)] = nht[CW'(c)] + 1;
                        if (c + 1 < PW) begin
                            nxt[CW'(c + 1)][HW'(nht[CW'(c + 1)])] =
                                (x0 & x1) | (x0 & x2) | (x1 & x2);
                            nht[CW'(c + 1)] = nht[CW'(c + 1)] + 1;
                        end
                        k   = k + 3;
                        rem = rem - 3;
                    end
                end
                while (rem > 0) begin
                    nxt[CW'(c)][HW'(nht[CW'(c)])] = col[CW'(c)][HW'(k)];
                    nht[CW'(c)] = nht[CW'(c)] + 1;
                    k   = k + 1;
                    rem = rem - 1;
                end
            end
            for (int unsigned c = 0; c < PW; c++) begin
                col[CW'(c)] = nxt[CW'(c)];
                ht[CW'(c)]  = nht[CW'(c)];
            end
        end

        for (int unsigned c = 0; c < PW; c++) begin
            row0[CW'(c)] = col[CW'(c)][0];
            row1[CW'(c)] = col[CW'(c)][1];
        end
        prod = row0 + row1;
    end

    // Select the requested half of the product; unknown opcodes give zero.
    always_comb begin
        y_d = '0;
        case (opcode)
            OP_MUL:                          y_d = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:    y_d = prod[PW-1:WIDTH];
            default:                         y_d = '0;
        endcase
    end

    // Result register; asynchronous reset clears it without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_q <= '0;
        else        y_q <= y_d;
    end

    assign Y = y_q;

endmodule

// File: tb/tb_mult_output.sv
// Scoreboard bench for mult_output: stimulus pushes expected results, a
// monitor pops one per clock and compares against Y.
module tb_mult_output;

    localparam logic [4:0] MUL    = 5'b01100;
    localparam logic [4:0] MULH   = 5'b01101;
    localparam logic [4:0] MULHSU = 5'b01110;
    localparam logic [4:0] MULHU  = 5'b01111;

    logic        clk;
    logic        rst_n;
    logic [63:0] A;
    logic [63:0] B;
    logic [4:0]  opcode;
    logic [63:0] Y;

    typedef struct {
        logic [63:0] exp;
        string       nm;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        string       nm;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mult_output #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .opcode(opcode),
        .Y     (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Independent 128-bit reference using sign/zero-extended operands.
    function automatic logic [63:0] ref_model(input logic [4:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [127:0] ea, eb, p;
        ea = {64'h0, a};
        eb = {64'h0, b};
        if (op == MULH || op == MULHSU) ea = {{64{a[63]}}, a};
        if (op == MULH)                 eb = {{64{b[63]}}, b};
        p = ea * eb;
        case (op)
            MUL:                  return p[63:0];
            MULH, MULHSU, MULHU:  return p[127:64];
            default:              return 64'h0;
        endcase
    endfunction

    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input string nm);
        exp_t e;
        @(negedge clk);
        opcode = op;
        A      = a;
        B      = b;
        e.exp  = exp;
        e.nm   = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: every capture edge retires one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.nm, Y, e.exp);
            end
        end
    end

    vec_t vecs[$];

    initial begin
        logic [63:0] ra, rb;
        logic [4:0]  rop;
        int          budget;

        vecs.push_back('{MUL,    64'd15, 64'd10, 64'd150, "mul_15x10"});
        vecs.push_back('{MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                         64'hFFFF_FFFF_FFFF_FFFE, "mulhu_ones"});
        vecs.push_back('{MULHU,  64'd7, 64'd6, 64'd0, "mulhu_7x6"});
        vecs.push_back('{MUL,    64'h1_0000_0000, 64'd2, 64'h2_0000_0000, "mul_pow2"});
        vecs.push_back('{MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "mulh_m1x2"});
        vecs.push_back('{MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu_m1x2"});
        vecs.push_back('{MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, "mulhu_m1x2"});
        vecs.push_back('{MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                         64'h4000_0000_0000_0000, "mulh_minxmin"});
        vecs.push_back('{5'b00000, 64'd15, 64'd10, 64'd0, "bad_op_00"});
        vecs.push_back('{MULHSU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                         64'h8000_0000_0000_0000, "mulhsu_min_ones"});
        vecs.push_back('{MUL,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                         64'h8000_0000_0000_0000, "mul_min_ones"});
        vecs.push_back('{MULH,   64'h8000_0000_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, "mulh_minx1"});
        vecs.push_back('{MULHU,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                         64'h4000_0000_0000_0000, "mulhu_2p63sq"});
        vecs.push_back('{MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "mul_ones"});
        vecs.push_back('{MUL,    64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "mul_zero"});
        vecs.push_back('{MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "mulh_m1xm1"});
        vecs.push_back('{5'b11111, 64'd3, 64'd3, 64'd0, "bad_op_1f"});
        vecs.push_back('{5'b01011, 64'd3, 64'd3, 64'd0, "bad_op_0b"});

        rst_n  = 1'b0;
        A      = 64'd5;
        B      = 64'd7;
        opcode = MUL;
        #2;
        check("reset_no_clock", Y, 64'h0);
        @(posedge clk);
        #1;
        check("reset_held", Y, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_release", Y, 64'h0);

        // Back-to-back directed vectors, one per cycle.
        foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);

        // Mid-operation reset.
        issue(MUL, 64'd15, 64'd10, 64'd150, "pre_reset_mul");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_clear", Y, 64'h0);
        @(posedge clk);
        #1;
        check("clear_hold_edge", Y, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("clear_after_release", Y, 64'h0);
        opcode = MUL;
        A      = 64'd9;
        B      = 64'd9;
        begin
            exp_t e;
            e.exp = 64'd81;
            e.nm  = "first_post_release";
            sb_q.push_back(e);
        end

        // Random operations against the 128-bit reference.
        for (int i = 0; i < 200; i++) begin
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rop = (i % 17 == 16) ? 5'($urandom_range(0, 31)) : 5'(MUL + 5'($urandom_range(0, 3)));
            if (i % 23 == 0) ra = 64'h8000_0000_0000_0000;
            if (i % 29 == 0) rb = 64'hFFFF_FFFF_FFFF_FFFF;
            issue(rop, ra, rb, ref_model(rop, ra, rb), "random");
        end

        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
